// File: rtl/sdf_pkg.sv
// sdf_pkg: shared constants and helpers for the SDF stage controller.
// Frame length N, feedback delay M and twiddle address shift.
package sdf_pkg;

  localparam int DEF_LOG_N = 6;
  localparam int DEF_LOG_M = 5;

  function automatic int n_of(input int log_n);
    return 1 << log_n;
  endfunction

  function automatic int m_of(input int log_m);
    return 1 << log_m;
  endfunction

  function automatic int tw_shift(input int log_n,
                                  input int log_m);
    return log_n - 1 - log_m;
  endfunction

endpackage

// File: rtl/sdf_mod_counter.sv
// sdf_mod_counter: enable-gated wrapping counter.
// Synchronous active-high reset; wraps 2**W-1 -> 0.
module sdf_mod_counter
  import sdf_pkg::*;
#(
  parameter int W = DEF_LOG_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_en,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_cnt;

  // Count one per enabled cycle, natural wrap.
  always_ff @(posedge clock) begin
    if (reset) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + W'(1);
  end

  assign o_q = r_cnt;

endmodule

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: control for one radix-2 single-path delay-feedback stage.
// Define SDF_STAGE_CTRL_TW_EN to generate registered twiddle addresses.
module sdf_stage_ctrl
  import sdf_pkg::*;
#(
  parameter int LOG_N = DEF_LOG_N,
  parameter int LOG_M = DEF_LOG_M
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  output logic             bf_en,
  output logic             buf_we,
  output logic [LOG_M-1:0] buf_addr,
  output logic             do_en,
  output logic             do_first,
  output logic             do_last,
  output logic [LOG_N-2:0] tw_addr
);

  localparam int N = n_of(LOG_N);

  logic [LOG_N-1:0] w_icnt;
  logic [LOG_N-1:0] w_ocnt;
  logic             w_bf;
  logic             w_take;
  logic             w_unused;
  logic             r_primed;
  logic             r_do_en;

  sdf_mod_counter #(.W(LOG_N)) u_icnt (
    .clock (clock),
    .reset (reset),
    .i_en  (di_en),
    .o_q   (w_icnt)
  );

  sdf_mod_counter #(.W(LOG_N)) u_ocnt (
    .clock (clock),
    .reset (reset),
    .i_en  (r_do_en),
    .o_q   (w_ocnt)
  );

  assign w_bf     = w_icnt[LOG_M];
  assign w_take   = di_en & (r_primed | w_bf);
  assign w_unused = ^w_icnt;

  assign bf_en    = w_bf;
  assign buf_we   = di_en;
  assign buf_addr = w_icnt[LOG_M-1:0];

  // Priming flag and one-cycle-delayed output valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_primed <= 1'b0;
      r_do_en  <= 1'b0;
    end else begin
      if (di_en & w_bf) r_primed <= 1'b1;
      r_do_en <= w_take;
    end
  end

  assign do_en    = r_do_en;
  assign do_first = r_do_en & (w_ocnt == '0);
  assign do_last  = r_do_en & (w_ocnt == LOG_N'(N - 1));

`ifdef SDF_STAGE_CTRL_TW_EN
  localparam int SH = tw_shift(LOG_N, LOG_M);

  logic [LOG_N-2:0] w_tw;
  logic [LOG_N-2:0] r_tw;

  assign w_tw = (LOG_N-1)'(w_icnt[LOG_M-1:0]) << SH;

  // Twiddle index only for y1 outputs (fill-phase samples after priming).
  always_ff @(posedge clock) begin
    if (reset) r_tw <= '0;
    else r_tw <= (w_take & ~w_bf) ? w_tw : '0;
  end

  assign tw_addr = r_tw;
`else
  assign tw_addr = '0;
`endif

endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 Parameter LOG_N, default 6, log2 of FFT frame length N.
REQ-002 Parameter LOG_M, default 5, log2 of stage feedback delay M; legal range 1..LOG_N-1.
REQ-003 Single clock; reset is synchronous and active-high; ports named clock and reset.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 di_en  input  1  input sample valid; may deassert at any cycle, including mid-frame.
REQ-007 bf_en  output  1  datapath mode: 1 = butterfly (di combined with delay output), 0 = fill/pass.
REQ-008 buf_we  output  1  delay buffer write enable.
REQ-009 buf_addr  output  LOG_M  delay buffer read/write address.
REQ-010 do_en  output  1  stage output sample valid.
REQ-011 do_first  output  1  marks first output sample of an N-sample output frame.
REQ-012 do_last  output  1  marks last output sample of an N-sample output frame.
REQ-013 tw_addr  output  LOG_N-1  twiddle ROM address for the current output sample.

Function
REQ-014 Input counter icnt (LOG_N bits) SHALL increment by 1 on each cycle with di_en=1, hold otherwise, wrap N-1 -> 0.
REQ-015 bf_en SHALL equal icnt[LOG_M], combinational from registered icnt, same cycle as the di sample.
REQ-016 buf_addr SHALL equal icnt[LOG_M-1:0]; buf_we SHALL equal di_en; both same cycle as the di sample.
REQ-017 Flag primed SHALL set on the first accepted sample with bf_en=1 and stay set until reset.
REQ-018 do_en SHALL assert exactly one cycle after each accepted sample that arrives with primed already set or with bf_en=1 (registered, latency 1).
REQ-019 Output counter ocnt (LOG_N bits) SHALL increment per do_en, wrap N-1 -> 0; do_first = do_en and ocnt==0; do_last = do_en and ocnt==N-1.
REQ-020 do_en for a bf_en=1 sample carries y0; for a bf_en=0 sample after priming, carries y1 of the previous block.
REQ-021 do_first, do_last SHALL never assert without do_en; do_en gaps SHALL mirror di_en gaps exactly.
REQ-022 Wrap of icnt and do_last in same cycle: both counters wrap independently; no sample lost or duplicated.

Reset
REQ-023 On reset: icnt=0, ocnt=0, primed=0; do_en, do_first, do_last, tw_addr = 0 in the following cycle.
REQ-024 Reset mid-frame SHALL discard the partial frame; next accepted sample is treated as icnt=0, no do_en until M further samples.
REQ-025 reset SHALL take priority over a simultaneous di_en.

Configuration
REQ-026 Macro SDF_STAGE_CTRL_TW_EN defined: tw_addr registered alongside do_en, equals buf_addr << (LOG_N-1-LOG_M) for y1 outputs, 0 for y0 outputs and when do_en=0.
REQ-027 Macro undefined: tw_addr port present, driven constant 0; no twiddle logic synthesized.

Structure
REQ-028 Shared package sdf_pkg SHALL hold derived constants N=2**LOG_N, M=2**LOG_M and the twiddle shift helper.
REQ-029 One sub-module sdf_mod_counter (enable-gated, wrapping, synchronous-reset counter), instantiated for icnt and ocnt.

Verification
REQ-030 LOG_N=6, LOG_M=5, reset then 64 contiguous di_en -> bf_en 0 for samples 0-31, 1 for 32-63; buf_addr 0..31 twice; first do_en the cycle after sample 32, with do_first=1.
REQ-031 3 contiguous frames (192 samples) -> 160 do_en pulses; do_last on do_en #64 and #128; do_first on #1, #65, #129.
REQ-032 di_en every other cycle for 64 samples -> per-sample bf_en/buf_addr identical to REQ-030; do_en pattern is the input pattern delayed 1 cycle.
REQ-033 reset at sample 40 -> next cycle all outputs 0; next sample buf_addr=0, bf_en=0; no do_en for the following 32 samples.
REQ-034 Macro defined, y1 output of block index j=5 -> tw_addr=5; macro undefined -> tw_addr=0 throughout.
REQ-035 LOG_M=1, LOG_N=3, contiguous input -> bf_en toggles 0,0,1,1,...; do_last every 8th do_en.
